ibex_fetch_stage: RTL and testbench
===================================

# ibex_fetch_stage

Parametrised instruction-fetch stage that replaces the fixed single-register IF/ID handoff with a configurable-depth instruction queue. It sits between an external prefetch buffer, which it drives through a branch request/address pair and a valid/ready stream, and the ID stage, which consumes through a valid/ready handshake. The block owns PC-redirect selection, including vectored IRQ and debug targets, boot-time initial redirect, queue flush on redirect, and compressed-instruction tagging.

## Interface
Parameters:
- DmHaltAddr, 32'h1A110800, debug-mode halt target (exc_pc_mux_i = 2).
- DmExceptionAddr, 32'h1A110808, debug exception target (exc_pc_mux_i = 3).
- QueueDepth, 2, IF/ID queue entries; legal range 1..8.
- CntW, $clog2(QueueDepth+1), derived occupancy width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- boot_addr_i  in  32  boot base; bits [7:0] unused.
- req_i  in  1  core fetch enable.
- pc_set_i  in  1  redirect strobe.
- pc_mux_i  in  3  redirect source: 0 BOOT, 1 JUMP, 2 EXC, 3 ERET, 4 DRET, others map to BOOT.
- exc_pc_mux_i  in  2  exception target: 0 EXC, 1 IRQ, 2 DBD, 3 DBG_EXC.
- exc_cause_i  in  6  IRQ id; bits [4:0] used.
- jump_target_ex_i, csr_mepc_i, csr_depc_i, csr_mtvec_i  in  32 each  redirect sources.
- csr_mtvec_init_o  out  1  pc_set_i & (pc_mux_i == 0).
- branch_req_o  out  1  prefetch redirect strobe.
- branch_addr_o  out  32  redirect target with bit 0 forced to 0.
- fetch_valid_i, fetch_err_i  in  1 each  prefetch entry valid and bus/PMP error.
- fetch_rdata_i, fetch_addr_i  in  32 each  prefetch instruction word and its PC.
- fetch_ready_o  out  1  queue accepts an entry.
- instr_valid_id_o  out  1  queue head valid.
- id_ready_i  in  1  ID consumes the head.
- instr_rdata_id_o, pc_id_o  out  32 each  head instruction word and PC.
- instr_fetch_err_o, instr_is_compressed_id_o  out  1 each  head error flag; head rdata[1:0] != 2'b11.
- queue_cnt_o  out  CntW  occupancy.
- perf_imiss_o  out  1  (count == 0) | branch_req_o.
- perf_stall_cnt_o  out  32  ID-starve cycle counter (see Configuration).

## Operation
- Exception target mux:
  - EXC: {mtvec[31:8], 8'h00}.
  - IRQ: {mtvec[31:8], 1'b0, cause[4:0], 2'b00}.
  - DBD: DmHaltAddr.
  - DBG_EXC: DmExceptionAddr.
- BOOT target: {boot_addr_i[31:8], 8'h80}.
- Init FSM states:
  - INIT, entered at reset: fetch_ready_o = 0. When req_i = 1, branch_req_o = 1 with the BOOT target and the FSM moves to RUN.
  - RUN: normal operation.
  - pc_set_i in either state asserts branch_req_o with the pc_mux_i target, and the next state is RUN.
- Queue: circular buffer of QueueDepth entries {rdata, addr, err}, with read pointer, write pointer and count.
  - Push when fetch_valid_i & fetch_ready_o.
  - Pop when instr_valid_id_o & id_ready_i.
  - Simultaneous push and pop leave count unchanged and advance both pointers. Pointers wrap at QueueDepth, including non-power-of-two depths.
- fetch_ready_o = RUN & ~pc_set_i & req_i & (count < QueueDepth). It has no pop pass-through, so a full queue with a same-cycle pop still refuses the entry.
- Flush: pc_set_i clears count and both pointers on the next edge. Flush overrides any same-cycle push. A same-cycle pop is still a legal consumption by ID.
- Head outputs are driven from storage at the read pointer. When count == 0, instr_valid_id_o = 0 and the data outputs hold their last value.

## Timing
- Reset values:
  - Outputs: instr_valid_id_o = 0, queue_cnt_o = 0, perf_stall_cnt_o = 0, fetch_ready_o = 0.
  - State: FSM = INIT; pointers and storage cleared to 0.
  - Outputs derived from those: instr_rdata_id_o = 0, pc_id_o = 0, instr_fetch_err_o = 0, instr_is_compressed_id_o = 1 (rdata = 0).
- branch_req_o and branch_addr_o are combinational from pc_set_i, pc_mux_i and the FSM in the same cycle.
- Latency: an entry pushed at edge N makes instr_valid_id_o = 1 from cycle N+1 (one cycle).
- Redirect at cycle N: queue empty from cycle N+1; the first new entry is accepted no earlier than N+1.
- Throughput is one entry per cycle at steady state.
- Reset asserted mid-operation drops all entries immediately and returns the FSM to INIT.

## Configuration
- IBEX_FETCH_PERF_CNT_EN defined:
  - perf_stall_cnt_o is a 32-bit counter.
  - It increments each cycle where RUN & req_i & id_ready_i & (count == 0).
  - It wraps 32'hFFFFFFFF -> 0 and is cleared only by reset.
- Undefined: perf_stall_cnt_o is tied to 0 and no counter flops exist.

## Test plan
- Boot: reset, boot_addr_i = 32'h0000_1000, req_i = 1 -> one-cycle branch_req_o with branch_addr_o = 32'h0000_1080. fetch_ready_o is 0 in that cycle and 1 the next.
- Fill/full, QueueDepth = 2, id_ready_i = 0, three fetches offered:
  - Two are accepted and queue_cnt_o = 2.
  - fetch_ready_o = 0 with the third held.
  - Release id_ready_i -> PCs pop in order.
- Flush: 2 entries queued, then pc_set_i with pc_mux_i = 1 and jump_target_ex_i = 32'h0000_2003 -> branch_addr_o = 32'h0000_2002 and queue_cnt_o = 0 next cycle. A same-cycle fetch is discarded.
- Vectored IRQ: mtvec = 32'h0000_4000, exc_pc_mux_i = 1, cause = 6'h07, pc_mux_i = 2 -> branch_addr_o = 32'h0000_401C.
- Tagging/error, two entries pushed:
  - fetch_rdata_i = 32'h0000_4501 -> compressed = 1.
  - fetch_rdata_i = 32'h0000_0013 with fetch_err_i = 1 -> compressed = 0, instr_fetch_err_o = 1 at the head.
- Stall counter, with the macro defined: RUN, req_i = 1, id_ready_i = 1, no fetch for 5 cycles -> perf_stall_cnt_o = 5. With the macro undefined it stays 0.

Source files
------------

// File: rtl/ibex_fetch_stage.sv
// Ibex instruction-fetch stage: PC-redirect selection plus a QueueDepth-entry IF/ID queue.
// Defining IBEX_FETCH_PERF_CNT_EN adds a 32-bit ID-starve stall counter.
module ibex_fetch_stage #(
  parameter logic [31:0] DmHaltAddr      = 32'h1A110800,
  parameter logic [31:0] DmExceptionAddr = 32'h1A110808,
  parameter int unsigned QueueDepth      = 2,
  parameter int unsigned CntW            = $clog2(QueueDepth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [31:0]     boot_addr_i,
  input  logic            req_i,
  input  logic            pc_set_i,
  input  logic [2:0]      pc_mux_i,
  input  logic [1:0]      exc_pc_mux_i,
  input  logic [5:0]      exc_cause_i,
  input  logic [31:0]     jump_target_ex_i,
  input  logic [31:0]     csr_mepc_i,
  input  logic [31:0]     csr_depc_i,
  input  logic [31:0]     csr_mtvec_i,
  output logic            csr_mtvec_init_o,
  output logic            branch_req_o,
  output logic [31:0]     branch_addr_o,
  input  logic            fetch_valid_i,
  input  logic            fetch_err_i,
  input  logic [31:0]     fetch_rdata_i,
  input  logic [31:0]     fetch_addr_i,
  output logic            fetch_ready_o,
  output logic            instr_valid_id_o,
  input  logic            id_ready_i,
  output logic [31:0]     instr_rdata_id_o,
  output logic [31:0]     pc_id_o,
  output logic            instr_fetch_err_o,
  output logic            instr_is_compressed_id_o,
  output logic [CntW-1:0] queue_cnt_o,
  output logic            perf_imiss_o,
  output logic [31:0]     perf_stall_cnt_o
);

  localparam int unsigned     PtrW    = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(QueueDepth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(QueueDepth);

  typedef enum logic {INIT, RUN} state_e;

  state_e          state_q;
  logic [31:0]     exc_pc, boot_pc, mux_pc, tgt_pc;
  logic            push, pop;
  logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q [QueueDepth];
  logic [31:0]     addr_q  [QueueDepth];
  logic            err_q   [QueueDepth];
  logic            unused_bits;

  assign unused_bits = ^{boot_addr_i[7:0], exc_cause_i[5], tgt_pc[0]};

  // Redirect target selection.
  assign boot_pc = {boot_addr_i[31:8], 8'h80};

  always_comb begin
    case (exc_pc_mux_i)
      2'd0:    exc_pc = {csr_mtvec_i[31:8], 8'h00};
      2'd1:    exc_pc = {csr_mtvec_i[31:8], 1'b0, exc_cause_i[4:0], 2'b00};
      2'd2:    exc_pc = DmHaltAddr;
      default: exc_pc = DmExceptionAddr;
    endcase
  end

  always_comb begin
    case (pc_mux_i)
      3'd1:    mux_pc = jump_target_ex_i;
      3'd2:    mux_pc = exc_pc;
      3'd3:    mux_pc = csr_mepc_i;
      3'd4:    mux_pc = csr_depc_i;
      default: mux_pc = boot_pc;
    endcase
  end

  // The first request after reset issues the boot redirect unless an explicit redirect wins.
  assign tgt_pc           = pc_set_i ? mux_pc : boot_pc;
  assign branch_addr_o    = {tgt_pc[31:1], 1'b0};
  assign branch_req_o     = pc_set_i | ((state_q == INIT) & req_i);
  assign csr_mtvec_init_o = pc_set_i & (pc_mux_i == 3'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
    end else if (pc_set_i || req_i) begin
      state_q <= RUN;
    end
  end

  assign fetch_ready_o    = (state_q == RUN) & ~pc_set_i & req_i & (cnt_q < FullCnt);
  assign instr_valid_id_o = (cnt_q != '0);
  assign push             = fetch_valid_i & fetch_ready_o;
  assign pop              = instr_valid_id_o & id_ready_i;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (pc_set_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // push is already gated off during a redirect, so no flush term is needed here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(QueueDepth); i++) begin
        rdata_q[i] <= '0;
        addr_q[i]  <= '0;
        err_q[i]   <= 1'b0;
      end
    end else if (push) begin
      rdata_q[wptr_q] <= fetch_rdata_i;
      addr_q[wptr_q]  <= fetch_addr_i;
      err_q[wptr_q]   <= fetch_err_i;
    end
  end

  assign instr_rdata_id_o         = rdata_q[rptr_q];
  assign pc_id_o                  = addr_q[rptr_q];
  assign instr_fetch_err_o        = err_q[rptr_q];
  assign instr_is_compressed_id_o = (rdata_q[rptr_q][1:0] != 2'b11);
  assign queue_cnt_o              = cnt_q;
  assign perf_imiss_o             = (cnt_q == '0) | branch_req_o;

`ifdef IBEX_FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if ((state_q == RUN) && req_i && id_ready_i && (cnt_q == '0)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
`else
  assign perf_stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_ibex_fetch_stage.sv
// Scoreboard bench for ibex_fetch_stage: a queue-based reference model predicts handshakes,
// redirect targets and head contents; a separate monitor pops and compares consumed entries.
`timescale 1ns/1ps
module tb_ibex_fetch_stage;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] HALT  = 32'h1A110800;
  localparam logic [31:0] DEXC  = 32'h1A110808;
`ifdef IBEX_FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   boot_addr, jump, mepc, depc, mtvec, fetch_rdata, fetch_addr;
  logic          req, pc_set, fetch_valid, fetch_err, id_ready;
  logic [2:0]    pc_mux;
  logic [1:0]    exc_pc_mux;
  logic [5:0]    cause;
  logic          csr_mtvec_init_o, branch_req_o, fetch_ready_o, instr_valid_id_o;
  logic [31:0]   branch_addr_o, instr_rdata_id_o, pc_id_o, perf_stall_cnt_o;
  logic          instr_fetch_err_o, instr_is_compressed_id_o, perf_imiss_o;
  logic [CW-1:0] queue_cnt_o;

  always #5 clk = ~clk;

  ibex_fetch_stage #(.QueueDepth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .boot_addr_i(boot_addr), .req_i(req),
    .pc_set_i(pc_set), .pc_mux_i(pc_mux), .exc_pc_mux_i(exc_pc_mux), .exc_cause_i(cause),
    .jump_target_ex_i(jump), .csr_mepc_i(mepc), .csr_depc_i(depc), .csr_mtvec_i(mtvec),
    .csr_mtvec_init_o(csr_mtvec_init_o), .branch_req_o(branch_req_o),
    .branch_addr_o(branch_addr_o), .fetch_valid_i(fetch_valid), .fetch_err_i(fetch_err),
    .fetch_rdata_i(fetch_rdata), .fetch_addr_i(fetch_addr), .fetch_ready_o(fetch_ready_o),
    .instr_valid_id_o(instr_valid_id_o), .id_ready_i(id_ready),
    .instr_rdata_id_o(instr_rdata_id_o), .pc_id_o(pc_id_o),
    .instr_fetch_err_o(instr_fetch_err_o), .instr_is_compressed_id_o(instr_is_compressed_id_o),
    .queue_cnt_o(queue_cnt_o), .perf_imiss_o(perf_imiss_o), .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  entry_t      exp_q[$];
  entry_t      pend_e;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          run_m = 1'b0;
  logic [31:0] stall_m = 32'd0;
  bit          acc_pend, flush_pend, stall_pend, run_pend;
  event        mon_ev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Redirect target straight from the address rules, using masks and arithmetic.
  function automatic logic [31:0] ref_target();
    logic [31:0] boot_t, base, t;
    boot_t = (boot_addr & 32'hFFFF_FF00) + 32'h80;
    base   = mtvec & 32'hFFFF_FF00;
    if (!pc_set) return boot_t;
    if (pc_mux == 3'd1)      t = jump;
    else if (pc_mux == 3'd2) begin
      if (exc_pc_mux == 2'd0)      t = base;
      else if (exc_pc_mux == 2'd1) t = base + 32'(cause[4:0]) * 4;
      else if (exc_pc_mux == 2'd2) t = HALT;
      else                         t = DEXC;
    end
    else if (pc_mux == 3'd3) t = mepc;
    else if (pc_mux == 3'd4) t = depc;
    else                     t = boot_t;
    return t & 32'hFFFF_FFFE;
  endfunction

  // Model: predicts per-cycle outputs from the expected occupancy at the start of the cycle.
  always @(negedge clk) begin
    int sz;
    bit exp_breq, exp_ready;
    acc_pend = 1'b0; flush_pend = 1'b0; stall_pend = 1'b0; run_pend = run_m;
    if (rst_n) begin
      sz        = exp_q.size();
      exp_breq  = pc_set || (!run_m && req);
      exp_ready = run_m && !pc_set && req && (sz < int'(DEPTH));
      chk("fetch_ready", 32'(fetch_ready_o), 32'(exp_ready));
      chk("branch_req", 32'(branch_req_o), 32'(exp_breq));
      if (exp_breq) chk("branch_addr", branch_addr_o, ref_target());
      chk("mtvec_init", 32'(csr_mtvec_init_o), 32'(pc_set && pc_mux == 3'd0));
      chk("queue_cnt", 32'(queue_cnt_o), 32'(sz));
      chk("imiss", 32'(perf_imiss_o), 32'(sz == 0 || exp_breq));
      chk("stall_cnt", perf_stall_cnt_o, PERF ? stall_m : 32'd0);
      acc_pend   = fetch_valid && exp_ready;
      pend_e     = '{fetch_rdata, fetch_addr, fetch_err};
      flush_pend = pc_set;
      stall_pend = run_m && req && id_ready && (sz == 0);
      run_pend   = run_m || pc_set || req;
      ->mon_ev;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      run_m   = 1'b0;
      stall_m = 32'd0;
    end else begin
      if (flush_pend)    exp_q.delete();
      else if (acc_pend) exp_q.push_back(pend_e);
      if (stall_pend) stall_m = stall_m + 32'd1;
      run_m = run_pend;
    end
    acc_pend = 1'b0; flush_pend = 1'b0; stall_pend = 1'b0;
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    run_m   = 1'b0;
    stall_m = 32'd0;
  end

  // Monitor: compares the presented head against the scoreboard and pops on consumption.
  always begin
    entry_t e;
    @(mon_ev);
    chk("instr_valid", 32'(instr_valid_id_o), 32'(exp_q.size() != 0));
    if (instr_valid_id_o && exp_q.size() != 0) begin
      e = exp_q[0];
      chk("head_rdata", instr_rdata_id_o, e.rdata);
      chk("head_pc", pc_id_o, e.addr);
      chk("head_err", 32'(instr_fetch_err_o), 32'(e.err));
      chk("head_compressed", 32'(instr_is_compressed_id_o), 32'(e.rdata[1:0] != 2'b11));
      if (id_ready) begin
        void'(exp_q.pop_front());
        $display("pop pc=%h rdata=%h err=%0d", e.addr, e.rdata, e.err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    pc_set = 1'b0; fetch_valid = 1'b0; fetch_err = 1'b0;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] d, input logic e);
    fetch_valid = 1'b1; fetch_addr = a; fetch_rdata = d; fetch_err = e;
  endtask

  initial begin
    boot_addr = 32'h0000_1000; jump = '0; mepc = '0; depc = '0; mtvec = '0;
    fetch_rdata = '0; fetch_addr = '0; req = 1'b0; pc_set = 1'b0; fetch_valid = 1'b0;
    fetch_err = 1'b0; id_ready = 1'b0; pc_mux = '0; exc_pc_mux = '0; cause = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(instr_valid_id_o), 32'd0);
    chk("rst_cnt", 32'(queue_cnt_o), 32'd0);
    chk("rst_stall", perf_stall_cnt_o, 32'd0);
    chk("rst_ready", 32'(fetch_ready_o), 32'd0);
    chk("rst_rdata", instr_rdata_id_o, 32'd0);
    chk("rst_pc", pc_id_o, 32'd0);
    chk("rst_err", 32'(instr_fetch_err_o), 32'd0);
    chk("rst_compressed", 32'(instr_is_compressed_id_o), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; req = 1'b1;

    // Boot redirect.
    @(negedge clk);
    chk("boot_req", 32'(branch_req_o), 32'd1);
    chk("boot_addr", branch_addr_o, 32'h0000_1080);
    chk("boot_ready", 32'(fetch_ready_o), 32'd0);
    step();
    @(negedge clk);
    chk("run_ready", 32'(fetch_ready_o), 32'd1);

    // Fill to full with ID stalled, including the compressed/error tagging entries.
    step(); offer(32'h0000_1080, 32'h0000_4501, 1'b0);
    step(); offer(32'h0000_1084, 32'h0000_0013, 1'b1);
    step(); offer(32'h0000_1088, 32'h0000_0093, 1'b0);
    @(negedge clk);
    chk("full_cnt", 32'(queue_cnt_o), 32'd2);
    chk("full_ready", 32'(fetch_ready_o), 32'd0);
    chk("tag_c_compressed", 32'(instr_is_compressed_id_o), 32'd1);
    step();
    step(); id_ready = 1'b1;
    @(negedge clk);
    chk("pop1_pc", pc_id_o, 32'h0000_1080);
    step();
    @(negedge clk);
    chk("pop2_pc", pc_id_o, 32'h0000_1084);
    chk("tag_e_compressed", 32'(instr_is_compressed_id_o), 32'd0);
    chk("tag_e_err", 32'(instr_fetch_err_o), 32'd1);
    step(); quiet();
    repeat (3) step();

    // Flush with two entries queued and a same-cycle fetch offered.
    id_ready = 1'b0;
    offer(32'h0000_3000, 32'h1111_1113, 1'b0);
    step(); offer(32'h0000_3004, 32'h2222_2223, 1'b0);
    step(); offer(32'h0000_3008, 32'h3333_3333, 1'b0);
    pc_set = 1'b1; pc_mux = 3'd1; jump = 32'h0000_2003;
    @(negedge clk);
    chk("flush_addr", branch_addr_o, 32'h0000_2002);
    chk("flush_ready", 32'(fetch_ready_o), 32'd0);
    step(); quiet();
    @(negedge clk);
    chk("flush_cnt", 32'(queue_cnt_o), 32'd0);
    chk("flush_valid", 32'(instr_valid_id_o), 32'd0);

    // Vectored IRQ target.
    step();
    pc_set = 1'b1; pc_mux = 3'd2; exc_pc_mux = 2'd1; cause = 6'h07; mtvec = 32'h0000_4000;
    @(negedge clk);
    chk("irq_addr", branch_addr_o, 32'h0000_401C);
    step(); quiet();

    // Randomised traffic checked by the model and monitor.
    for (int c = 0; c < 1500; c++) begin
      req         = ($urandom_range(0, 9) != 0);
      pc_set      = ($urandom_range(0, 19) == 0);
      pc_mux      = 3'($urandom_range(0, 7));
      exc_pc_mux  = 2'($urandom_range(0, 3));
      cause       = 6'($urandom);
      jump        = $urandom; mepc = $urandom; depc = $urandom; mtvec = $urandom;
      if ($urandom_range(0, 49) == 0) boot_addr = $urandom;
      fetch_valid = ($urandom_range(0, 9) < 7);
      fetch_rdata = $urandom; fetch_addr = $urandom;
      fetch_err   = ($urandom_range(0, 9) == 0);
      id_ready    = ($urandom_range(0, 9) < 6);
      step();
    end

    // Fill, then reset mid-cycle: entries must vanish immediately.
    quiet(); req = 1'b1; id_ready = 1'b0;
    pc_set = 1'b1; pc_mux = 3'd1; jump = 32'h0000_5000;
    step(); pc_set = 1'b0; offer(32'h0000_5000, 32'h0000_0013, 1'b0);
    step(); offer(32'h0000_5004, 32'h0000_0013, 1'b0);
    step(); quiet();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(instr_valid_id_o), 32'd0);
    chk("midrst_cnt", 32'(queue_cnt_o), 32'd0);
    step(); step();

    // Stall counter: five starved RUN cycles after the boot cycle.
    rst_n = 1'b1; req = 1'b1; id_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    chk("stall_five", perf_stall_cnt_o, PERF ? 32'd5 : 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
